// File: rtl/vec_pkg.sv
// vec_pkg: shared lane/element types and byte-walk helpers for the vector store path.
`default_nettype none

package vec_pkg;

    localparam int NLANES     = 4;
    localparam int LANE_W     = 16;
    localparam int NBYTES_MAX = NLANES * LANE_W / 8;
    localparam int CNT_W      = $clog2(NBYTES_MAX + 1);
    localparam int LANE_IW    = $clog2(NLANES);

    typedef enum logic {SZ8 = 1'b0, SZ16 = 1'b1} elem_size_e;
    typedef enum logic [0:0] {IDLE = 1'b0, WRITE = 1'b1} vst_state_e;
    typedef logic [NLANES-1:0][LANE_W-1:0] lane_vec_t;

    function automatic logic [CNT_W-1:0] nbytes(input elem_size_e sz);
        return (sz == SZ16) ? CNT_W'(2 * NLANES) : CNT_W'(NLANES);
    endfunction

    // First enabled byte index at or after 'from'; nbytes(sz) when none remain.
    function automatic logic [CNT_W-1:0] next_byte(input logic [NLANES-1:0] mask,
                                                   input elem_size_e      sz,
                                                   input logic [CNT_W-1:0] from);
        logic [CNT_W-1:0]   res;
        logic [CNT_W-1:0]   kk;
        logic [LANE_IW-1:0] ln;
        logic               found;
        res   = nbytes(sz);
        found = 1'b0;
        for (int k = 0; k < NBYTES_MAX; k++) begin
            kk = CNT_W'(k);
            ln = (sz == SZ16) ? kk[LANE_IW:1] : kk[LANE_IW-1:0];
            if (!found && kk >= from && kk < nbytes(sz) && mask[ln]) begin
                res   = kk;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vec_byte_sel.sv
// vec_byte_sel: picks the byte at index i_idx from the captured lane vector.
`default_nettype none

module vec_byte_sel
    import vec_pkg::*;
(
    input  lane_vec_t        i_vec,
    input  elem_size_e       i_size,
    input  logic [CNT_W-1:0] i_idx,
    output logic [7:0]       o_byte
);

    logic [LANE_IW-1:0] w_lane;
    logic               w_hi;

    assign w_lane = (i_size == SZ16) ? i_idx[LANE_IW:1] : i_idx[LANE_IW-1:0];
    assign w_hi   = (i_size == SZ16) & i_idx[0];

    always_comb begin
        o_byte = 8'h00;
        if (i_idx < nbytes(i_size))
            o_byte = w_hi ? i_vec[w_lane][15:8] : i_vec[w_lane][7:0];
    end

endmodule

`default_nettype wire

// File: rtl/vec_store_unit.sv
// vec_store_unit: writes the 4 lane results of a vst to byte memory, one byte per accepted cycle.
// Optional macro STORE_MASK_EN adds the per-lane in_mask write-enable port.
`default_nettype none

module vec_store_unit
    import vec_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NLANES*LANE_W-1:0] in_res,
    input  logic                     in_size,
    input  logic [ADDR_W-1:0]        in_addr,
`ifdef STORE_MASK_EN
    input  logic [NLANES-1:0]        in_mask,
`endif
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [7:0]               mem_wdata,
    input  logic                     mem_ready,
    output logic                     busy,
    output logic                     done
);

    vst_state_e          r_state;
    vst_state_e          w_state_nxt;
    lane_vec_t           r_vec;
    elem_size_e          r_size;
    logic [ADDR_W-1:0]   r_base;
    logic [NLANES-1:0]   r_mask;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_done;

    logic [NLANES-1:0]   w_mask_in;
    elem_size_e          w_size_in;
    logic [CNT_W-1:0]    w_first;
    logic                w_first_none;
    logic [CNT_W-1:0]    w_next;
    logic                w_last;
    logic                w_accept;
    logic                w_capture;

`ifdef STORE_MASK_EN
    assign w_mask_in = in_mask;
`else
    assign w_mask_in = '1;
`endif

    assign w_size_in    = elem_size_e'(in_size);
    assign w_first      = next_byte(w_mask_in, w_size_in, '0);
    assign w_first_none = (w_first == nbytes(w_size_in));
    assign w_capture    = (r_state == IDLE) && in_valid;
    assign w_accept     = mem_we && mem_ready;
    // Masked-off bytes are skipped without spending a cycle.
    assign w_next       = next_byte(r_mask, r_size, r_cnt + CNT_W'(1));
    assign w_last       = (w_next == nbytes(r_size));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid && !w_first_none) w_state_nxt = WRITE;
            WRITE:   if (w_accept && w_last)         w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == IDLE);
        busy     = (r_state == WRITE);
        mem_we   = (r_state == WRITE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec  <= '0;
            r_size <= SZ8;
            r_base <= '0;
            r_mask <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (w_capture && w_first_none) || (w_accept && w_last);
            if (w_capture) begin
                r_vec  <= lane_vec_t'(in_res);
                r_size <= w_size_in;
                r_base <= in_addr;
                r_mask <= w_mask_in;
                r_cnt  <= w_first;
            end else if (w_accept) begin
                r_cnt  <= w_next;
            end
        end
    end

    assign mem_addr = r_base + ADDR_W'(r_cnt);
    assign done     = r_done;

    vec_byte_sel u_byte_sel (
        .i_vec  (r_vec),
        .i_size (r_size),
        .i_idx  (r_cnt),
        .o_byte (mem_wdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_vec_store_unit.sv
// tb_vec_store_unit: directed + randomized vst stores checked against a byte-list reference model.
`default_nettype none

module tb_vec_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_res;
    logic        in_size;
    logic [15:0] in_addr;
    logic [3:0]  in_mask;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready;
    logic        busy;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vec_store_unit #(.ADDR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .in_size   (in_size),
        .in_addr   (in_addr),
`ifdef STORE_MASK_EN
        .in_mask   (in_mask),
`endif
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mode 0: memory always ready; 1: random stalls; 2: 3 stall cycles on the second byte.
    task automatic store(input logic [63:0] res, input logic sz, input logic [15:0] base,
                         input logic [3:0] mask, input int mode, input int exp_cycles);
        wr_t q[$];
        int  nb, lane, cyc, popped, stall_run;
        logic rdy;
`ifndef STORE_MASK_EN
        mask = 4'hF;
`endif
        nb = sz ? 8 : 4;
        for (int k = 0; k < nb; k++) begin
            lane = sz ? k / 2 : k;
            if (mask[lane])
                q.push_back({base + 16'(k), res[lane*16 + (sz ? (k % 2) * 8 : 0) +: 8]});
        end
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_res   = res;
        in_size  = sz;
        in_addr  = base;
        in_mask  = mask;
        @(negedge clk);
        cyc = 0; popped = 0; stall_run = 0;
        while (q.size() > 0 && cyc < 300) begin
            chk("mem_we", {31'd0, mem_we}, 32'd1);
            chk("busy", {31'd0, busy}, 32'd1);
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            chk("mem_addr", {16'd0, mem_addr}, {16'd0, q[0].a});
            chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, q[0].d});
            // Garbage on the request port must be ignored while storing.
            in_valid = 1'($urandom);
            in_res   = {$urandom, $urandom};
            in_size  = 1'($urandom);
            in_addr  = 16'($urandom);
            in_mask  = 4'($urandom);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    rdy = !(popped == 1 && stall_run < 3);
                    if (!rdy) stall_run++;
                end
            endcase
            mem_ready = rdy;
            if (rdy) begin
                popped++;
                void'(q.pop_front());
            end
            @(negedge clk);
            cyc++;
        end
        chk("store_timeout", q.size(), 0);
        in_valid = 1'b0;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("mem_we_after", {31'd0, mem_we}, 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("in_ready_after", {31'd0, in_ready}, 32'd1);
        if (exp_cycles >= 0)
            chk("write_cycles", cyc, exp_cycles);
    endtask

    localparam logic [63:0] DATA = 64'h7788_5566_3344_1122;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_res = '0; in_size = 1'b0;
        in_addr = '0; in_mask = '0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 16-bit elements: 8 write cycles, done on cycle 10 counting the capture as cycle 1.
        store(DATA, 1'b1, 16'h0100, 4'hF, 0, 8);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);

        store(DATA, 1'b0, 16'h0200, 4'hF, 0, 4);
        @(negedge clk);
        chk("no_write_past_end", {31'd0, mem_we}, 32'd0);

        store(DATA, 1'b1, 16'h0400, 4'hF, 2, 11);
        store(DATA, 1'b0, 16'hFFFE, 4'hF, 0, 4);

        // Reset in the middle of a 16-bit store, on the third byte.
        in_valid = 1'b1; in_res = {$urandom, $urandom}; in_size = 1'b1; in_addr = 16'h0300;
        mem_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_addr", {16'd0, mem_addr}, 32'h0302);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_we", {31'd0, mem_we}, 32'd0);
        chk("rst_async_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_we", {31'd0, mem_we}, 32'd0);
        chk("post_rst_done", {31'd0, done}, 32'd0);
        store(DATA, 1'b1, 16'h0500, 4'hF, 0, 8);

`ifdef STORE_MASK_EN
        store(DATA, 1'b1, 16'h0600, 4'b0101, 0, 4);
        @(negedge clk);
        chk("mask_done_once", {31'd0, done}, 32'd0);
        store(DATA, 1'b1, 16'h0700, 4'b0000, 0, 0);
`endif

        // Randomized stores, sometimes back-to-back with the previous done.
        for (int i = 0; i < 24; i++) begin
            store({$urandom, $urandom}, 1'($urandom),
                  ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'hFFF8 + 16'($urandom_range(0, 7)),
                  4'($urandom), 1, -1);
            if ($urandom_range(0, 1) != 0) begin
                @(negedge clk);
                chk("rand_done_one_cycle", {31'd0, done}, 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
